adder_axi_master: RTL and testbench



---
 rtl/adder_axi_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_adder_axi_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_axi_master.sv
// adder_axi_master: AXI-Lite master that runs one add job on a memory-mapped adder peripheral.
// It writes opA and opB, reads back the sum and the overflow flag, and returns the result.
//
// Ports
//   m1_axi_aclk, m1_axi_areset      clock; asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_opa/b  job request handshake and operands
//   rsp_valid/rsp_ready             result handshake
//   rsp_sum, rsp_ovf, rsp_err       read-back sum, overflow bit 0, job failed
//   m1_axi_aw*, w*, b*, ar*, r*     AXI-Lite master channels
// All outputs come straight from flops.
module adder_axi_master #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           TIMEOUT    = 255
) (
    input  logic                      m1_axi_aclk,
    input  logic                      m1_axi_areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DATA_WIDTH-1:0]     cmd_opa,
    input  logic [DATA_WIDTH-1:0]     cmd_opb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_sum,
    output logic                      rsp_ovf,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     m1_axi_awaddr,
    output logic                      m1_axi_awvalid,
    input  logic                      m1_axi_awready,
    output logic [DATA_WIDTH-1:0]     m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m1_axi_wstrb,
    output logic                      m1_axi_wvalid,
    input  logic                      m1_axi_wready,
    input  logic [1:0]                m1_axi_bresp,
    input  logic                      m1_axi_bvalid,
    output logic                      m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m1_axi_araddr,
    output logic                      m1_axi_arvalid,
    input  logic                      m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m1_axi_rdata,
    input  logic [1:0]                m1_axi_rresp,
    input  logic                      m1_axi_rvalid,
    output logic                      m1_axi_rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        StIdle, StWrA, StWbA, StWrB, StWbB, StRdSum, StRrSum, StRdOvf, StRrOvf, StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    ovf_q, ovf_d, err_q, err_d;
    logic                    cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                    bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    aw_pend, w_pend, timed_out, fail, entering;

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        fail      = 1'b0;
        // A channel is still pending if its valid is up and the slave has not taken it yet.
        aw_pend   = awvalid_q && !m1_axi_awready;
        w_pend    = wvalid_q && !m1_axi_wready;
        timed_out = (cnt_q == TimeoutC);

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    opa_d   = cmd_opa;
                    opb_d   = cmd_opb;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StWrA;
                end
            end
            StWrA, StWrB: begin
                if (!aw_pend && !w_pend) begin
                    state_d = (state_q == StWrA) ? StWbA : StWbB;
                end else if (timed_out) begin
                    fail = 1'b1;
                end else begin
                    awvalid_d = aw_pend;
                    wvalid_d  = w_pend;
                end
            end
            StWbA, StWbB: begin
                if (m1_axi_bvalid && bready_q) begin
                    if (m1_axi_bresp != 2'b00) begin
                        fail = 1'b1;
                    end else begin
                        state_d = (state_q == StWbA) ? StWrB : StRdSum;
                    end
                end else if (timed_out) begin
                    fail = 1'b1;
                end
            end
            StRdSum, StRdOvf: begin
                if (m1_axi_arready && arvalid_q) begin
                    state_d = (state_q == StRdSum) ? StRrSum : StRrOvf;
                end else if (timed_out) begin
                    fail = 1'b1;
                end
            end
            StRrSum, StRrOvf: begin
                if (m1_axi_rvalid && rready_q) begin
                    if (m1_axi_rresp != 2'b00) begin
                        fail = 1'b1;
                    end else if (state_q == StRrSum) begin
                        sum_d   = m1_axi_rdata;
                        state_d = StRdOvf;
                    end else begin
                        ovf_d   = m1_axi_rdata[0];
                        state_d = StDone;
                    end
                end else if (timed_out) begin
                    fail = 1'b1;
                end
            end
            StDone: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Any failure discards partial results so the response carries only the error flag.
        if (fail) begin
            err_d   = 1'b1;
            sum_d   = '0;
            ovf_d   = 1'b0;
            state_d = StDone;
        end

        entering = (state_d != state_q);

        // Address and data are loaded only on state entry so they hold steady while valid.
        if (entering && (state_d == StWrA || state_d == StWrB)) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wstrb_d   = '1;
            awaddr_d  = (state_d == StWrA) ? BASE_ADDR : BASE_ADDR + ADDR_WIDTH'(4);
            wdata_d   = (state_d == StWrA) ? opa_d : opb_q;
        end
        if (entering && state_d == StRdSum) araddr_d = BASE_ADDR + ADDR_WIDTH'(8);
        if (entering && state_d == StRdOvf) araddr_d = BASE_ADDR + ADDR_WIDTH'(12);

        bready_d    = (state_d == StWbA) || (state_d == StWbB);
        arvalid_d   = (state_d == StRdSum) || (state_d == StRdOvf);
        rready_d    = (state_d == StRrSum) || (state_d == StRrOvf);
        cmd_ready_d = (state_d == StIdle);
        // Response is raised the cycle after DONE entry, once the result registers have settled.
        rsp_valid_d = (state_q == StDone) && !(rsp_valid_q && rsp_ready);

        if (entering) begin
            cnt_d = '0;
        end else if (cnt_q != TimeoutC) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_sum        = sum_q;
    assign rsp_ovf        = ovf_q;
    assign rsp_err        = err_q;
    assign m1_axi_awaddr  = awaddr_q;
    assign m1_axi_awvalid = awvalid_q;
    assign m1_axi_wdata   = wdata_q;
    assign m1_axi_wstrb   = wstrb_q;
    assign m1_axi_wvalid  = wvalid_q;
    assign m1_axi_bready  = bready_q;
    assign m1_axi_araddr  = araddr_q;
    assign m1_axi_arvalid = arvalid_q;
    assign m1_axi_rready  = rready_q;

endmodule

// File: tb/tb_adder_axi_master.sv
module tb_adder_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_opa = '0, cmd_opb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_sum;
    logic        rsp_ovf, rsp_err;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b1, wready = 1'b1, arready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        s_err_b = 1'b0;

    int checks = 0;
    int errors = 0;

    adder_axi_master dut (
        .m1_axi_aclk    (clk),
        .m1_axi_areset  (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_opa        (cmd_opa),
        .cmd_opb        (cmd_opb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_sum        (rsp_sum),
        .rsp_ovf        (rsp_ovf),
        .rsp_err        (rsp_err),
        .m1_axi_awaddr  (awaddr),
        .m1_axi_awvalid (awvalid),
        .m1_axi_awready (awready),
        .m1_axi_wdata   (wdata),
        .m1_axi_wstrb   (wstrb),
        .m1_axi_wvalid  (wvalid),
        .m1_axi_wready  (wready),
        .m1_axi_bresp   (s_bresp),
        .m1_axi_bvalid  (s_bvalid),
        .m1_axi_bready  (bready),
        .m1_axi_araddr  (araddr),
        .m1_axi_arvalid (arvalid),
        .m1_axi_arready (arready),
        .m1_axi_rdata   (s_rdata),
        .m1_axi_rresp   (s_rresp),
        .m1_axi_rvalid  (s_rvalid),
        .m1_axi_rready  (rready)
    );

    logic [92:0] all_outs;
    assign all_outs = {cmd_ready, rsp_valid, rsp_sum, rsp_ovf, rsp_err, awaddr, awvalid, wdata,
                       wstrb, wvalid, bready, araddr, arvalid, rready};

    // Adder peripheral: registered responses one cycle after each handshake.
    logic        aw_got, w_got, aw_have, w_have, aw_hs, w_hs;
    logic [7:0]  aw_addr_l, aw_addr_cur;
    logic [31:0] w_data_l, w_data_cur, reg_a, reg_b;
    logic [32:0] s_full;
    logic [7:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [3:0]  wr_strb_log[$];
    logic [7:0]  rd_addr_log[$];

    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign aw_have     = aw_got | aw_hs;
    assign w_have      = w_got | w_hs;
    assign aw_addr_cur = aw_hs ? awaddr : aw_addr_l;
    assign w_data_cur  = w_hs ? wdata : w_data_l;
    assign s_full      = {1'b0, reg_a} + {1'b0, reg_b};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_addr_l <= '0; w_data_l <= '0;
            reg_a <= '0; reg_b <= '0;
            s_bvalid <= 1'b0; s_bresp <= 2'b00; s_rvalid <= 1'b0; s_rresp <= 2'b00;
            s_rdata <= '0;
            wr_addr_log.delete(); wr_data_log.delete(); wr_strb_log.delete();
            rd_addr_log.delete();
        end else begin
            if (w_hs) wr_strb_log.push_back(wstrb);
            if (aw_have && w_have && !s_bvalid) begin
                if (aw_addr_cur == 8'h00) reg_a <= w_data_cur;
                if (aw_addr_cur == 8'h04) reg_b <= w_data_cur;
                s_bvalid <= 1'b1;
                s_bresp  <= (aw_addr_cur == 8'h04 && s_err_b) ? 2'b10 : 2'b00;
                wr_addr_log.push_back(aw_addr_cur);
                wr_data_log.push_back(w_data_cur);
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= awaddr; end
                if (w_hs) begin w_got <= 1'b1; w_data_l <= wdata; end
            end
            if (s_bvalid && bready) s_bvalid <= 1'b0;
            if (arvalid && arready && !s_rvalid) begin
                s_rvalid <= 1'b1;
                s_rresp  <= 2'b00;
                s_rdata  <= (araddr == 8'h08) ? s_full[31:0] :
                            (araddr == 8'h0C) ? {31'b0, s_full[32]} : 32'h0;
                rd_addr_log.push_back(araddr);
            end
            if (s_rvalid && rready) s_rvalid <= 1'b0;
        end
    end

    task automatic do_reset();
        awready = 1'b1; wready = 1'b1; arready = 1'b1; s_err_b = 1'b0;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #4 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Returns #1 after the accept edge, cmd_valid already dropped.
    task automatic start_job(input logic [31:0] a, input logic [31:0] b, output bit tmo);
        int n = 0;
        tmo = 1'b0;
        cmd_opa = a; cmd_opb = b; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin tmo = 1'b1; cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input bit ack,
                           output logic [31:0] sum, output logic ovf, output logic err,
                           output int lat, output bit tmo);
        lat = 0; sum = 'x; ovf = 1'bx; err = 1'bx;
        start_job(a, b, tmo);
        if (tmo) return;
        while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin tmo = 1'b1; return; end
        sum = rsp_sum; ovf = rsp_ovf; err = rsp_err;
        if (ack) begin rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0; end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_pre_edge: got %b want 0", cmd_ready); end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_after_release: got %b want 1", cmd_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] sum; logic ovf, err; int lat; bit tmo;
        do_reset();
        run_job(32'd5, 32'd7, 1'b1, sum, ovf, err, lat, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL basic_timeout: got stuck want completion"); end
        checks++;
        if ({sum, ovf, err} !== {32'd12, 1'b0, 1'b0})
            begin errors++; $display("FAIL basic_result: got sum=%0d ovf=%b err=%b want 12 0 0", sum, ovf, err); end
        checks++;
        if (lat != 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
        checks++;
        if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 8'h00 || wr_addr_log[1] !== 8'h04)
            begin errors++; $display("FAIL basic_wr_addr: got %p want 0,4", wr_addr_log); end
        checks++;
        if (wr_data_log.size() != 2 || wr_data_log[0] !== 32'd5 || wr_data_log[1] !== 32'd7)
            begin errors++; $display("FAIL basic_wr_data: got %p want 5,7", wr_data_log); end
        checks++;
        if (wr_strb_log.size() != 2 || wr_strb_log[0] !== 4'hF || wr_strb_log[1] !== 4'hF)
            begin errors++; $display("FAIL basic_wstrb: got %p want F,F", wr_strb_log); end
        checks++;
        if (rd_addr_log.size() != 2 || rd_addr_log[0] !== 8'h08 || rd_addr_log[1] !== 8'h0C)
            begin errors++; $display("FAIL basic_rd_addr: got %p want 8,C", rd_addr_log); end
    endtask

    task automatic test_overflow();
        logic [31:0] sum; logic ovf, err; int lat; bit tmo;
        do_reset();
        run_job(32'hFFFF_FFFF, 32'd1, 1'b1, sum, ovf, err, lat, tmo);
        checks++;
        if (tmo || {sum, ovf, err} !== {32'd0, 1'b1, 1'b0})
            begin errors++; $display("FAIL overflow: got sum=%h ovf=%b err=%b tmo=%b want 0 1 0", sum, ovf, err, tmo); end
    endtask

    task automatic test_random();
        logic [31:0] sum, a, b; logic ovf, err; int lat; bit tmo;
        logic [32:0] full;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            a = $urandom; b = $urandom;
            if (i == 0) b = ~a;
            if (i == 1) b = ~a + 32'd1;
            full = {1'b0, a} + {1'b0, b};
            run_job(a, b, 1'b1, sum, ovf, err, lat, tmo);
            checks++;
            if (tmo || {sum, ovf, err} !== {full[31:0], full[32], 1'b0})
                begin errors++; $display("FAIL random_%0d: a=%h b=%h got %h/%b/%b want %h/%b/0", i, a, b, sum, ovf, err, full[31:0], full[32]); end
            checks++;
            if (lat != 9) begin errors++; $display("FAIL random_latency_%0d: got %0d want 9", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sum; logic ovf, err; int lat; bit tmo;
        do_reset();
        run_job(32'd100, 32'd23, 1'b0, sum, ovf, err, lat, tmo);
        checks++;
        if (tmo || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got cmd_ready=%b tmo=%b want 0 0", cmd_ready, tmo); end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL b2b_ready_return: got %b want 10", {cmd_ready, rsp_valid}); end
        run_job(32'd40, 32'd2, 1'b1, sum, ovf, err, lat, tmo);
        checks++;
        if (tmo || sum !== 32'd42 || lat != 9) begin errors++; $display("FAIL b2b_second: got sum=%0d lat=%0d want 42 9", sum, lat); end
    endtask

    task automatic test_timeout();
        bit tmo; int n = 0;
        do_reset();
        awready = 1'b0;
        start_job(32'd1, 32'd2, tmo);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (tmo || {awvalid, wvalid, awaddr} !== {1'b1, 1'b0, 8'h00})
            begin errors++; $display("FAIL timeout_valids: got aw=%b w=%b addr=%h want 1 0 00", awvalid, wvalid, awaddr); end
        n = 2;
        while (!rsp_valid && n < 1000) begin @(posedge clk); #1; n++; end
        checks++;
        if (!rsp_valid || {rsp_sum, rsp_ovf, rsp_err} !== {32'd0, 1'b0, 1'b1})
            begin errors++; $display("FAIL timeout_rsp: got v=%b sum=%h err=%b want 1 0 1", rsp_valid, rsp_sum, rsp_err); end
        checks++;
        if (n < 255 || n > 260) begin errors++; $display("FAIL timeout_cycles: got %0d want about 257", n); end
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0)
            begin errors++; $display("FAIL timeout_quiet: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_bresp_err();
        logic [31:0] sum; logic ovf, err; int lat; bit tmo;
        do_reset();
        s_err_b = 1'b1;
        run_job(32'd3, 32'd4, 1'b0, sum, ovf, err, lat, tmo);
        checks++;
        if (tmo || {sum, ovf, err} !== {32'd0, 1'b0, 1'b1})
            begin errors++; $display("FAIL bresp_rsp: got sum=%h ovf=%b err=%b want 0 0 1", sum, ovf, err); end
        checks++;
        if (rd_addr_log.size() != 0 || wr_addr_log.size() != 2)
            begin errors++; $display("FAIL bresp_traffic: got rd=%0d wr=%0d want 0 2", rd_addr_log.size(), wr_addr_log.size()); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_sum, rsp_ovf, rsp_err, cmd_ready} !== {1'b1, 32'd0, 1'b0, 1'b1, 1'b0})
                begin errors++; $display("FAIL bresp_hold_%0d: got v=%b sum=%h e=%b rdy=%b want 1 0 1 0", i, rsp_valid, rsp_sum, rsp_err, cmd_ready); end
        end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bresp_release: got %b want 1", cmd_ready); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] sum; logic ovf, err; int lat; bit tmo; int n = 0;
        do_reset();
        start_job(32'd9, 32'd10, tmo);
        while (!(rready && rd_addr_log.size() == 1) && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (tmo || !rready) begin errors++; $display("FAIL midrst_reach: got rready=%b want 1", rready); end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL midrst_outs: got %h want 0", all_outs); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL midrst_ready: got %b want 10", {cmd_ready, rsp_valid}); end
        run_job(32'd100, 32'd200, 1'b1, sum, ovf, err, lat, tmo);
        checks++;
        if (tmo || {sum, ovf, err} !== {32'd300, 1'b0, 1'b0} || lat != 9)
            begin errors++; $display("FAIL midrst_next: got sum=%0d err=%b lat=%0d want 300 0 9", sum, err, lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_back_to_back();
        test_timeout();
        test_bresp_err();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
